register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 32, number of entries; minimum 2.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 SHALL read as zero and ignore writes.
REQ-004 Derived AW = max(1, clog2(DEPTH)) SHALL size all address ports.
REQ-005 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 we  input  1  write request this cycle.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 wstrb  input  WIDTH/8  byte write enables; bit i covers wdata[8i+7:8i].
REQ-012 raddr_a  input  AW  read port A address.
REQ-013 rdata_a  output  WIDTH  read port A data, registered.
REQ-014 raddr_b  input  AW  read port B address.
REQ-015 rdata_b  output  WIDTH  read port B data, registered.
REQ-016 clr_req  input  1  start clear sweep (single-cycle pulse or level).
REQ-017 clr_busy  output  1  high while clear sweep runs.

Function
REQ-018 Write: on clk edge with we=1, clr_busy=0, waddr<DEPTH, entry waddr SHALL update only bytes with wstrb bit set; other bytes hold.
REQ-019 Writes with wstrb=0, waddr>=DEPTH, or waddr=0 with ZERO_REG=1 SHALL change no state.
REQ-020 Read latency: rdata_x SHALL present contents of raddr_x exactly 1 cycle after the address is sampled.
REQ-021 Write-first bypass: read and write to same address in same cycle SHALL return the post-write merged value (strobed bytes new, others old).
REQ-022 Both ports SHALL operate independently; same address on A and B SHALL yield identical data.
REQ-023 Read of raddr>=DEPTH, or address 0 with ZERO_REG=1, SHALL return 0.
REQ-024 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR when clr_req=1; pointer loads 0.
REQ-025 In CLEAR, one entry per cycle SHALL be zeroed, pointer incrementing 0..DEPTH-1; CLEAR->IDLE after entry DEPTH-1 zeroed (DEPTH cycles total).
REQ-026 clr_busy SHALL be 1 exactly in CLEAR state, asserting the cycle after clr_req sampled.
REQ-027 clr_req while in CLEAR SHALL be ignored (no restart).
REQ-028 we while clr_busy=1 SHALL be dropped, not queued.
REQ-029 clr_req and we in same IDLE cycle: the write SHALL complete, then the sweep SHALL zero it.
REQ-030 Reads during CLEAR SHALL remain valid, returning 0 for already-swept entries and old data otherwise; same-cycle sweep of read address SHALL return 0 (bypass).

Reset
REQ-031 rst=1 at clk edge SHALL zero all entries, rdata_a, rdata_b, pointer, and force IDLE (clr_busy=0).
REQ-032 rst SHALL take priority over we, clr_req and an in-progress sweep; sweep is abandoned, not resumed.
REQ-033 First write SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-034 Write 0xDEADBEEF to addr 5, wstrb=0xF; next cycle raddr_a=5 -> rdata_a=0xDEADBEEF one cycle later.
REQ-035 Addr 5=0xDEADBEEF, write 0x11223344 wstrb=0x5 while raddr_b=5 same cycle -> rdata_b=0xDE22BE44 next cycle.
REQ-036 ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> both ports read 0 at addr 0.
REQ-037 Fill all entries, pulse clr_req -> clr_busy high 32 cycles (DEPTH=32), write during sweep dropped, all entries read 0 afterward.
REQ-038 Assert rst mid-sweep at pointer 10 -> next cycle clr_busy=0, all entries and both rdata 0.
REQ-039 DEPTH=20: write to addr 25 -> no entry changes; read addr 25 -> 0.

Source files
------------

// File: rtl/register_file.sv
// Multi-ported register file: byte-strobed write, two registered read ports with
// write-first bypass, and a one-entry-per-cycle clear sweep.

module register_file_entry #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               clr,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   nxt
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] merged;

  for (genvar b = 0; b < WIDTH/8; b++) begin : g_byte
    assign merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : q[8*b +: 8];
  end

  // nxt is the post-edge value; the read ports mux it directly for bypass.
  always_comb begin
    nxt = q;
    if (clr)     nxt = '0;
    else if (wr) nxt = merged;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= nxt;
  end
endmodule

module register_file #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wstrb,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr_req,
  output logic             clr_busy
);
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t                      state, state_nxt;
  logic   [AW-1:0]             ptr, ptr_nxt;
  logic   [DEPTH-1:0][WIDTH-1:0] nxt;
  logic                        in_w, in_a, in_b;
  logic                        ok_w, ok_a, ok_b;
  logic                        wr_en;

  // Range checks only exist when the address space is larger than DEPTH.
  if (DEPTH == (1 << AW)) begin : g_full
    assign in_w = 1'b1;
    assign in_a = 1'b1;
    assign in_b = 1'b1;
  end else begin : g_part
    assign in_w = (waddr   < AW'(DEPTH));
    assign in_a = (raddr_a < AW'(DEPTH));
    assign in_b = (raddr_b < AW'(DEPTH));
  end

  assign ok_w  = in_w && ((ZERO_REG == 0) || (waddr   != '0));
  assign ok_a  = in_a && ((ZERO_REG == 0) || (raddr_a != '0));
  assign ok_b  = in_b && ((ZERO_REG == 0) || (raddr_b != '0));
  assign wr_en = we && !clr_busy && ok_w && (|wstrb);

  assign clr_busy = (state == CLEAR);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    register_file_entry #(.WIDTH(WIDTH)) u_ent (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr_en && (waddr == AW'(i))),
      .clr   (clr_busy && (ptr == AW'(i))),
      .wstrb (wstrb),
      .wdata (wdata),
      .nxt   (nxt[i])
    );
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: if (clr_req) begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
      CLEAR: begin
        ptr_nxt = ptr + AW'(1);
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      rdata_a <= ok_a ? nxt[raddr_a] : '0;
      rdata_b <= ok_b ? nxt[raddr_b] : '0;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: two instances (32 deep with zero register, 20 deep without)
// share stimulus and are checked each cycle against an array model, plus literal vectors.

module tb_register_file;
  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [4:0]  raddr_a, raddr_b;
  logic        clr_req;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        bz [2];

  int vectors     = 0;
  int miscompares = 0;

  register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(ra[0]), .raddr_b(raddr_b), .rdata_b(rb[0]),
    .clr_req(clr_req), .clr_busy(bz[0])
  );

  register_file #(.WIDTH(32), .DEPTH(20), .ZERO_REG(0)) u_dut20 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(ra[1]), .raddr_b(raddr_b), .rdata_b(rb[1]),
    .clr_req(clr_req), .clr_busy(bz[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: memory contents, sweep flag and sweep position per instance.
  logic [31:0] mm [2][32];
  bit          mb [2];
  int          mp [2];
  logic [31:0] ea [2];
  logic [31:0] eb [2];
  int          dp [2] = '{32, 20};
  bit          zr [2] = '{1'b1, 1'b0};

  function automatic logic [31:0] rd(input int k, input logic [4:0] a);
    if (int'(a) < dp[k] && !(zr[k] && a == 5'd0)) return mm[k][a];
    return 32'h0;
  endfunction

  // Inputs change just after negedge, so at negedge they still hold what the last posedge sampled.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
        mb[k] = 1'b0;
        mp[k] = 0;
        ea[k] = 32'h0;
        eb[k] = 32'h0;
      end else begin
        if (!mb[k]) begin
          if (we && int'(waddr) < dp[k] && !(zr[k] && waddr == 5'd0))
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) mm[k][waddr][8*b +: 8] = wdata[8*b +: 8];
          if (clr_req) begin
            mb[k] = 1'b1;
            mp[k] = 0;
          end
        end else begin
          mm[k][mp[k]] = 32'h0;
          mp[k]++;
          if (mp[k] == dp[k]) mb[k] = 1'b0;
        end
        ea[k] = rd(k, raddr_a);
        eb[k] = rd(k, raddr_b);
      end
      chk($sformatf("model_rdata_a[%0d]", k), ra[k], ea[k]);
      chk($sformatf("model_rdata_b[%0d]", k), rb[k], eb[k]);
      chk($sformatf("model_clr_busy[%0d]", k), {31'h0, bz[k]}, {31'h0, mb[k]});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    tick();
    we = 1'b0; wstrb = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
    tick(); tick();
    chk("reset_rdata_a", ra[0], 32'h0);
    chk("reset_clr_busy", {31'h0, bz[0]}, 32'h0);

    // First write accepted on the first edge after reset drops.
    rst = 1'b0;
    wr(5'd1, 32'h0102_0304, 4'hF);
    raddr_a = 5'd1;
    tick();
    chk("first_write", ra[0], 32'h0102_0304);

    wr(5'd5, 32'hDEAD_BEEF, 4'hF);
    raddr_a = 5'd5;
    tick();
    chk("full_write_5", ra[0], 32'hDEAD_BEEF);

    raddr_b = 5'd5;
    wr(5'd5, 32'h1122_3344, 4'h5);
    chk("bypass_merge_b", rb[0], 32'hDE22_BE44);
    chk("bypass_merge_b_d20", rb[1], 32'hDE22_BE44);

    wr(5'd0, 32'hFFFF_FFFF, 4'hF);
    raddr_a = 5'd0; raddr_b = 5'd0;
    tick();
    chk("zero_reg_a", ra[0], 32'h0);
    chk("zero_reg_b", rb[0], 32'h0);
    chk("no_zero_reg_d20", ra[1], 32'hFFFF_FFFF);

    raddr_a = 5'd9;
    wr(5'd9, 32'hAABB_CCDD, 4'hF);
    wr(5'd9, 32'h1111_1111, 4'h2);
    chk("strobe_byte1", ra[0], 32'hAABB_11DD);
    wr(5'd9, 32'h2222_2222, 4'h8);
    wr(5'd9, 32'hFFFF_FFFF, 4'h0);
    chk("strobe_none", ra[0], 32'h22BB_11DD);

    wr(5'd25, 32'hCAFE_F00D, 4'hF);
    raddr_a = 5'd25; raddr_b = 5'd25;
    tick();
    chk("oor_read_d20", ra[1], 32'h0);
    chk("inrange_25_d32", ra[0], 32'hCAFE_F00D);

    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i);
      wr(5'(i), 32'h1000_0000 + 32'(i) * 32'h0101, 4'hF);
    end

    // Write and clear request in the same idle cycle: write lands, sweep zeroes it later.
    we = 1'b1; waddr = 5'd3; wdata = 32'h3333_3333; wstrb = 4'hF; clr_req = 1'b1;
    raddr_a = 5'd3;
    tick();
    we = 1'b0; clr_req = 1'b0; wstrb = 4'h0;
    chk("wr_with_clr", ra[0], 32'h3333_3333);
    chk("busy_after_req", {31'h0, bz[0]}, 32'h1);

    n = 0;
    while (bz[0] && n < 40) begin
      n++;
      we = (n == 3); waddr = 5'd7; wdata = 32'h7777_7777; wstrb = 4'hF;
      clr_req = (n == 5);
      raddr_b = 5'(n);
      tick();
    end
    we = 1'b0; clr_req = 1'b0; wstrb = 4'h0;
    chk("sweep_cycles", 32'(n), 32'd32);

    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i);
      tick();
      if (i == 3 || i == 7 || i == 31) chk($sformatf("swept_%0d", i), ra[0], 32'h0);
    end

    wr(5'd10, 32'hA0A0_A0A0, 4'hF);
    wr(5'd12, 32'hC0C0_C0C0, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1; raddr_a = 5'd12; raddr_b = 5'd10;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", {31'h0, bz[0]}, 32'h0);
    chk("rst_mid_a", ra[0], 32'h0);
    chk("rst_mid_b", rb[0], 32'h0);
    tick();
    chk("rst_mid_entry12", ra[0], 32'h0);
    tick();
    chk("no_resume", {31'h0, bz[0]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
